mspeckey_enc_iter: RTL and testbench
====================================

MSPECKEY_ENC_ITER -- requirements
Module: mspeckey_enc_iter

Interface
REQ-001 Parameter: ROUNDS, default 4, number of forward rounds applied per block; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_data holds a block to encode.
REQ-005 in_ready  output  1  block can accept input this cycle.
REQ-006 in_data  input  16  plaintext state: [15:8] = Hi half, [7:0] = Lo half.
REQ-007 out_valid  output  1  out_data holds the finished ciphertext.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  16  encoded state: [15:8] = X, [7:0] = Y.
REQ-010 busy  output  1  high while in state RUN or DONE.
REQ-011 round_cnt  output  8  number of rounds completed on the current block.

Function
REQ-012 Forward round on 16-bit state S = {Hi, Lo}, 8-bit modular arithmetic, carries discarded:
  - X = rotl8(Hi, 1) + Lo (mod 256)
  - Y = rotl8(Lo, 2) XOR X
  - the new state is {X, Y}.
REQ-013 The round is the exact inverse of the team's mSPECKEY decryption round: Lo = rotr8(X^Y, 2), Hi = rotr8(X − Lo, 1). Decoding an output ROUNDS times returns the original input.
REQ-014 The FSM has three states: IDLE, RUN and DONE. It has no other reachable states.
REQ-015 IDLE:
  - in_ready = 1, out_valid = 0, busy = 0.
  - On in_valid && in_ready, the state register loads in_data, round_cnt clears to 0, and the FSM goes to RUN.
REQ-016 RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle, the state register takes the round of its current value and round_cnt increments by 1.
  - When round_cnt reaches ROUNDS, the FSM goes to DONE.
REQ-017 Exactly ROUNDS rounds are applied. There is no round in the acceptance cycle and no round in DONE.
REQ-018 Latency: for an acceptance edge at cycle T, out_valid first rises after edge T+ROUNDS.
REQ-019 DONE:
  - out_valid = 1, in_ready = 0, out_data = the state register.
  - out_data and round_cnt hold stable while out_ready = 0, for any number of cycles.
REQ-020 In DONE, out_valid && out_ready returns the FSM to IDLE on that edge. in_ready rises in the following cycle; there is no same-cycle accept on output handoff.
REQ-021 in_valid is ignored outside IDLE, and in_data is sampled only on the acceptance edge. in_data changes after acceptance do not affect the result.
REQ-022 out_ready is ignored outside DONE.
REQ-023 out_data drives the state register in all states. Its value is defined by this spec only while out_valid = 1.
REQ-024 Throughput: at most one block per ROUNDS+2 cycles with out_ready held high.

Reset
REQ-025 While rst_n = 0, regardless of clk:
  - FSM = IDLE; state register = 0x0000; round_cnt = 0.
  - in_ready = 1, out_valid = 0, busy = 0, out_data = 0x0000.
REQ-026 Assertion of rst_n during RUN or DONE abandons the in-flight block: no out_valid pulse, no partial result retained.
REQ-027 After reset deassertion, the first block is accepted on the first rising edge with in_valid = 1.

Verification
REQ-028 ROUNDS=1, in_data=0x0001, out_ready=1 → out_valid after 1 RUN cycle, out_data=0x0105, round_cnt=1.
REQ-029 ROUNDS=2, in_data=0x0001 → out_data=0x0713; decoding it twice gives 0x0001.
REQ-030 Carry wrap: ROUNDS=1, in_data=0xFFFF → out_data=0xFE01. This checks that the 9th sum bit is dropped.
REQ-031 Backpressure and input isolation:
  - Stimulus: ROUNDS=4, any input, out_ready=0 for 10 cycles in DONE; in_valid=1 with changing in_data throughout.
  - Response: out_data and round_cnt stable, in_ready=0, no second acceptance.
  - Then out_ready=1 → IDLE next edge, in_ready=1 the cycle after.
REQ-032 Reset mid-operation: rst_n low during RUN round 2 → outputs per REQ-025 immediately (asynchronous). After release, 0x0001 with ROUNDS=1 yields 0x0105.
REQ-033 Random self-check: ≥1000 random blocks with random in_valid/out_ready stalls. Each output is checked against the REQ-012 model, and ROUNDS inverse rounds must recover the input.

Source files
------------

// File: rtl/mspeckey_enc_iter.sv
// mspeckey_enc_iter: iterative mSPECKEY forward (encode) engine.
// One 16-bit block is loaded, ROUNDS forward rounds are applied one per
// cycle, and the result is held until the downstream handshake completes.
module mspeckey_enc_iter #(
    parameter int ROUNDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic [7:0]  round_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count value seen during the final RUN cycle; the round applied on
    // that edge brings round_cnt up to ROUNDS as the FSM enters DONE.
    localparam logic [7:0] LAST = 8'(ROUNDS - 1);

    state_t      state, state_nxt;
    logic [15:0] blk;

    // One forward round: X = rotl(Hi,1) + Lo, Y = rotl(Lo,2) ^ X (mod 256).
    function automatic logic [15:0] fwd_round(input logic [15:0] s);
        logic [7:0] x, y;
        x = {s[14:8], s[15]} + s[7:0];
        y = {s[5:0], s[7:6]} ^ x;
        return {x, y};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; handoff always passes through IDLE before a new accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)              state_nxt = RUN;
            RUN:     if (round_cnt == LAST)     state_nxt = DONE;
            DONE:    if (out_ready)             state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // Datapath: load on accept, one round per RUN cycle, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk       <= 16'h0000;
            round_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    blk       <= in_data;
                    round_cnt <= 8'd0;
                end
                RUN: begin
                    blk       <= fwd_round(blk);
                    round_cnt <= round_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_data = blk;

endmodule

// File: tb/tb_mspeckey_enc_iter.sv
// Bench for mspeckey_enc_iter: three instances (ROUNDS = 1, 2, 4) share one
// stimulus stream; directed steps first, then a randomized handshake run
// scored against an arithmetic model of the cipher.
module tb_mspeckey_enc_iter;

    localparam int RS [3] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        ir [3];
    logic        ov [3];
    logic        bz [3];
    logic [15:0] od [3];
    logic [7:0]  rc [3];

    int n_tot  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    mspeckey_enc_iter #(.ROUNDS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .busy(bz[0]), .round_cnt(rc[0]));
    mspeckey_enc_iter #(.ROUNDS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .busy(bz[1]), .round_cnt(rc[1]));
    mspeckey_enc_iter #(.ROUNDS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .busy(bz[2]), .round_cnt(rc[2]));

    // Reference cipher written with plain integer arithmetic.
    function automatic logic [15:0] enc1(input logic [15:0] s);
        int hi, lo, x, y;
        hi = int'(s[15:8]);
        lo = int'(s[7:0]);
        x  = ((hi * 2) % 256 + hi / 128 + lo) % 256;
        y  = ((lo * 4) % 256 + lo / 64) ^ x;
        return 16'(x * 256 + y);
    endfunction

    function automatic logic [15:0] dec1(input logic [15:0] s);
        int x, y, v, lo, d, hi;
        x  = int'(s[15:8]);
        y  = int'(s[7:0]);
        v  = x ^ y;
        lo = v / 4 + (v % 4) * 64;
        d  = (x - lo + 256) % 256;
        hi = d / 2 + (d % 2) * 128;
        return 16'(hi * 256 + lo);
    endfunction

    function automatic logic [15:0] enc(input logic [15:0] s, input int n);
        logic [15:0] t = s;
        for (int k = 0; k < n; k++) t = enc1(t);
        return t;
    endfunction

    function automatic logic [15:0] dec(input logic [15:0] s, input int n);
        logic [15:0] t = s;
        for (int k = 0; k < n; k++) t = dec1(t);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        out_ready = 1'b0;
    endtask

    // Transaction scoreboard: each instance holds at most one block.
    logic [15:0] pend      [3];
    bit          has_pend  [3];
    bit          stall_prev[3];
    logic [15:0] od_prev   [3];
    int          done4 = 0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (stall_prev[i]) chk("hold_data", {16'd0, od[i]}, {16'd0, od_prev[i]});
                if (ov[i] && out_ready) begin
                    chk("rand_pending", {31'd0, has_pend[i]}, 32'd1);
                    chk("rand_enc", {16'd0, od[i]}, {16'd0, enc(pend[i], RS[i])});
                    chk("rand_inverse", {16'd0, dec(od[i], RS[i])}, {16'd0, pend[i]});
                    has_pend[i] = 1'b0;
                    if (i == 2) done4++;
                end
                if (ir[i] && in_valid) begin
                    pend[i]     = in_data;
                    has_pend[i] = 1'b1;
                end
                stall_prev[i] = ov[i] && !out_ready;
                od_prev[i]    = od[i];
            end
        end
    end

    initial begin
        logic [15:0] r, exp4;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            has_pend[i] = 1'b0; stall_prev[i] = 1'b0; od_prev[i] = '0; pend[i] = '0;
        end
        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
        #3;
        // Reset values, asserted before any clock edge.
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", {31'd0, ir[i]}, 32'd1);
            chk("rst_out_valid", {31'd0, ov[i]}, 32'd0);
            chk("rst_busy", {31'd0, bz[i]}, 32'd0);
            chk("rst_out_data", {16'd0, od[i]}, 32'd0);
            chk("rst_round_cnt", {24'd0, rc[i]}, 32'd0);
        end
        step(); step();
        rst_n = 1'b1;

        // Basic vectors and latency: accept 0x0001 on all instances.
        in_data = 16'h0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 16'hdead;
        chk("acc_busy", {31'd0, bz[0]}, 32'd1);
        chk("acc_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("acc_in_ready", {31'd0, ir[0]}, 32'd0);
        step();
        chk("r1_valid", {31'd0, ov[0]}, 32'd1);
        chk("r1_data", {16'd0, od[0]}, 32'h0105);
        chk("r1_cnt", {24'd0, rc[0]}, 32'd1);
        chk("r2_early", {31'd0, ov[1]}, 32'd0);
        step();
        chk("r2_valid", {31'd0, ov[1]}, 32'd1);
        chk("r2_data", {16'd0, od[1]}, 32'h0713);
        chk("r2_inverse", {16'd0, dec(od[1], 2)}, 32'h0001);
        chk("r1_hold", {16'd0, od[0]}, 32'h0105);
        step();
        chk("r4_early", {31'd0, ov[2]}, 32'd0);
        step();
        chk("r4_valid", {31'd0, ov[2]}, 32'd1);
        chk("r4_data", {16'd0, od[2]}, {16'd0, enc(16'h0001, 4)});
        chk("r4_cnt", {24'd0, rc[2]}, 32'd4);
        drain();

        // Carry wrap: 0xFF + 0xFF must drop the ninth bit.
        in_data = 16'hffff; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("carry_wrap", {16'd0, od[0]}, 32'hfe01);
        drain();

        // Backpressure with in_valid high and in_data churning.
        r = 16'($urandom);
        exp4 = enc(r, 4);
        in_data = r; in_valid = 1'b1;
        step();
        repeat (4) begin
            in_data = 16'($urandom);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            chk("bp_data", {16'd0, od[2]}, {16'd0, exp4});
            chk("bp_cnt", {24'd0, rc[2]}, 32'd4);
            chk("bp_in_ready", {31'd0, ir[2]}, 32'd0);
            chk("bp_valid", {31'd0, ov[2]}, 32'd1);
            in_data = 16'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_valid_drop", {31'd0, ov[2]}, 32'd0);
        chk("hs_in_ready", {31'd0, ir[2]}, 32'd1);
        chk("hs_no_reload", {16'd0, od[2]}, {16'd0, exp4});
        drain();

        // Asynchronous reset during the second RUN round.
        in_data = 16'h1234; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("amid_in_ready", {31'd0, ir[2]}, 32'd1);
        chk("amid_valid", {31'd0, ov[2]}, 32'd0);
        chk("amid_busy", {31'd0, bz[2]}, 32'd0);
        chk("amid_data", {16'd0, od[2]}, 32'd0);
        chk("amid_cnt", {24'd0, rc[2]}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", {31'd0, ov[2]}, 32'd0);
        in_data = 16'h0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_r1", {16'd0, od[0]}, 32'h0105);
        drain();

        // Randomized handshakes scored by the monitor.
        mon_en = 1'b1;
        cyc = 0;
        while (done4 < 1000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = 16'($urandom);
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        mon_en = 1'b0;
        chk("rand_block_count", {31'd0, (done4 >= 1000)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
